// File: rtl/btn_event_ctrl.sv
// Front-panel button controller: sync + debounce per button, press/release/repeat
// detection, and a round-robin serializer onto one valid/ready event port.

module btn_event_lane #(
  parameter int STABLE_TICKS = 20,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int CW           = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s,
  input  logic       tick,
  input  logic       rep_en,
  output logic       level,
  output logic       post,
  output logic [1:0] post_kind
);
  localparam logic [1:0] K_PRESS = 2'b00, K_RELEASE = 2'b01, K_REPEAT = 2'b10;
  localparam logic [CW-1:0] ST_C = CW'(STABLE_TICKS);
  localparam logic [CW-1:0] RD_C = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RR_C = CW'(REPEAT_RATE);

  typedef enum logic [2:0] {RELEASED, PRESS_WAIT, HELD, REPEATING, RELEASE_WAIT} st_t;
  st_t st, st_n;
  logic [CW-1:0] sc, sc_n, rc, rc_n, sc_inc, rc_inc;
  logic was_rep, was_rep_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= RELEASED;
      sc      <= '0;
      rc      <= '0;
      was_rep <= 1'b0;
    end else begin
      st      <= st_n;
      sc      <= sc_n;
      rc      <= rc_n;
      was_rep <= was_rep_n;
    end
  end

  assign sc_inc = (&sc) ? sc : sc + 1'b1;
  assign rc_inc = (&rc) ? rc : rc + 1'b1;
  assign level  = (st == HELD) || (st == REPEATING) || (st == RELEASE_WAIT);

  always_comb begin
    st_n      = st;
    sc_n      = sc;
    rc_n      = rc;
    was_rep_n = was_rep;
    post      = 1'b0;
    post_kind = K_PRESS;
    case (st)
      RELEASED:
        if (s) begin st_n = PRESS_WAIT; sc_n = '0; end
      PRESS_WAIT:
        if (!s) st_n = RELEASED;
        else if (tick) begin
          sc_n = sc_inc;
          if (sc_inc >= ST_C) begin
            st_n = HELD; rc_n = '0; post = 1'b1; post_kind = K_PRESS;
          end
        end
      HELD:
        if (!s) begin st_n = RELEASE_WAIT; sc_n = '0; was_rep_n = 1'b0; end
        else if (tick && rep_en) begin
          rc_n = rc_inc;
          if (rc_inc >= RD_C) begin
            st_n = REPEATING; rc_n = '0; post = 1'b1; post_kind = K_REPEAT;
          end
        end
      REPEATING:
        if (!s) begin st_n = RELEASE_WAIT; sc_n = '0; was_rep_n = 1'b1; end
        else if (!rep_en) begin st_n = HELD; rc_n = '0; end
        else if (tick) begin
          rc_n = rc_inc;
          if (rc_inc >= RR_C) begin rc_n = '0; post = 1'b1; post_kind = K_REPEAT; end
        end
      RELEASE_WAIT:
        // a bounce back to pressed resumes where we left off, rc untouched
        if (s) st_n = was_rep ? REPEATING : HELD;
        else if (tick) begin
          sc_n = sc_inc;
          if (sc_inc >= ST_C) begin
            st_n = RELEASED; post = 1'b1; post_kind = K_RELEASE;
          end
        end
      default: st_n = RELEASED;
    endcase
  end
endmodule

module btn_event_ctrl #(
  parameter int NUM_BTN      = 4,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 20,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  localparam int IDW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic [NUM_BTN-1:0] repeat_en,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [IDW-1:0]     evt_id,
  output logic [1:0]         evt_kind,
  output logic               overrun
);
  localparam int PW    = $clog2(TICK_DIV);
  localparam int CMAX0 = (STABLE_TICKS > REPEAT_DELAY) ? STABLE_TICKS : REPEAT_DELAY;
  localparam int CMAX  = (CMAX0 > REPEAT_RATE) ? CMAX0 : REPEAT_RATE;
  localparam int CW    = $clog2(CMAX + 1);

  logic [NUM_BTN-1:0] s1, s, post, flag, grant;
  logic [NUM_BTN-1:0][1:0] post_kind, kind;
  logic [PW-1:0]  pcnt;
  logic           tick, load, any;
  logic [IDW-1:0] win, ptr;
  int             idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s    <= '0;
      pcnt <= '0;
    end else begin
      s1   <= btn_in;
      s    <= s1;
      pcnt <= tick ? '0 : pcnt + 1'b1;
    end
  end

  assign tick = (pcnt == PW'(TICK_DIV - 1));

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
    btn_event_lane #(
      .STABLE_TICKS(STABLE_TICKS), .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE(REPEAT_RATE), .CW(CW)
    ) u_lane (
      .clk(clk), .rst_n(rst_n), .s(s[i]), .tick(tick), .rep_en(repeat_en[i]),
      .level(btn_level[i]), .post(post[i]), .post_kind(post_kind[i])
    );
  end

  // scan downwards so the lowest offset from ptr wins
  always_comb begin
    any = 1'b0;
    win = '0;
    idx = 0;
    for (int k = NUM_BTN - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_BTN;
      if (flag[idx]) begin any = 1'b1; win = IDW'(idx); end
    end
  end

  assign load = !evt_valid || evt_ready;

  always_comb begin
    grant = '0;
    if (load && any) grant[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag      <= '0;
      kind      <= '0;
      overrun   <= 1'b0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_kind  <= 2'b00;
      ptr       <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (post[i]) begin
          flag[i] <= 1'b1;
          kind[i] <= post_kind[i];
        end else if (grant[i]) begin
          flag[i] <= 1'b0;
        end
      end
      overrun <= |(post & flag & ~grant);
      if (load) begin
        evt_valid <= any;
        if (any) begin
          evt_id   <= win;
          evt_kind <= kind[win];
          ptr      <= (win == IDW'(NUM_BTN - 1)) ? '0 : win + 1'b1;
        end
      end
    end
  end
endmodule
